// File: rtl/position_sync_gen.sv
// position_sync_gen: per-slice position_sync/turn_sync generator fed by fixed-rate, ramped or hall-sensor timing
// Ports: clk, nrst (async active-low reset); mode 0 off / 1 emulate / 2 ramp / 3 external;
// slice_period target cycles per slice; hall_in raw active-low hall sensors (sensor 0 = index);
// position_sync / turn_sync slice and turn start pulses; slice_idx current slice;
// turn_period / period_valid measured cycles per turn; stalled no index edge within counter range.
module position_sync_gen #(
  parameter int SLICES     = 256,
  parameter int NB_SENSORS = 1,
  parameter int PERIOD_W   = 24,
  parameter int DEBOUNCE   = 16,
  parameter int RAMP_START = 4096
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [1:0]                mode,
  input  logic [PERIOD_W-1:0]       slice_period,
  input  logic [NB_SENSORS-1:0]     hall_in,
  output logic                      position_sync,
  output logic                      turn_sync,
  output logic [$clog2(SLICES)-1:0] slice_idx,
  output logic [PERIOD_W-1:0]       turn_period,
  output logic                      period_valid,
  output logic                      stalled
);
  localparam int IW = $clog2(SLICES);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [PERIOD_W-1:0] PMAX = '1;
  localparam logic [PERIOD_W-1:0] RS = PERIOD_W'(RAMP_START);
  logic [1:0] mode_q;
  logic [NB_SENSORS-1:0] s1, s2, deb, fall, pend;
  logic [PERIOD_W-1:0] sp1, p1, ramp, p2, p3, tp_sh, p, tmr, tcnt;
  logic [IW-1:0] ev_idx;
  logic ev, wrap, run, seen0, last;
  int k;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= hall_in;
      s2 <= s1;
    end
  // fall fires in the cycle the debounced level is about to drop, so the event is queued without an extra edge-detect stage
  for (genvar i = 0; i < NB_SENSORS; i++) begin : g_deb
    logic [DW-1:0] cnt;
    logic d;
    assign deb[i] = d;
    assign fall[i] = d & ~s2[i] & (cnt == DW'(DEBOUNCE - 1));
    always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
        cnt <= '0;
        d <= 1'b1;
      end else if (s2[i] == d) cnt <= '0;
      else if (cnt == DW'(DEBOUNCE - 1)) begin
        cnt <= '0;
        d <= s2[i];
      end else cnt <= cnt + 1'b1;
  end
  always_comb begin
    k = 0;
    for (int i = NB_SENSORS - 1; i >= 0; i--) if (pend[i]) k = i;
  end
  assign ev = |pend;
  assign ev_idx = IW'(k * (SLICES / NB_SENSORS));
  assign sp1 = slice_period == '0 ? PERIOD_W'(1) : slice_period;
  assign p2 = sp1 > ramp ? sp1 : ramp;
  assign tp_sh = turn_period >> IW;
  assign p3 = tp_sh == '0 ? PERIOD_W'(1) : tp_sh;
  assign p = mode_q == 2'd1 ? p1 : mode_q == 2'd2 ? p2 : p3;
  assign wrap = tmr >= p - 1'b1;
  assign last = slice_idx == IW'(SLICES - 1);
  assign run = mode_q == 2'd1 || mode_q == 2'd2 || (mode_q == 2'd3 && period_valid);
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      mode_q <= 2'd0;
      tmr <= '0;
      slice_idx <= '0;
      position_sync <= 1'b0;
      turn_sync <= 1'b0;
      p1 <= PERIOD_W'(1);
      ramp <= RS;
      tcnt <= '0;
      turn_period <= '0;
      period_valid <= 1'b0;
      stalled <= 1'b0;
      seen0 <= 1'b0;
      pend <= '0;
    end else begin
      position_sync <= 1'b0;
      turn_sync <= 1'b0;
      mode_q <= mode;
      if (mode != mode_q) begin
        tmr <= '0;
        slice_idx <= '0;
        p1 <= sp1;
        ramp <= RS;
        tcnt <= '0;
        pend <= '0;
        stalled <= 1'b0;
        seen0 <= 1'b0;
        if (mode == 2'd3) period_valid <= 1'b0;
      end else begin
        if (mode_q == 2'd3) begin
          pend <= (pend & ~(NB_SENSORS'(1) << k)) | fall;
          tcnt <= tcnt == PMAX ? PMAX : tcnt + 1'b1;
          if (tcnt == PMAX) begin
            stalled <= 1'b1;
            period_valid <= 1'b0;
            seen0 <= 1'b0;
          end
        end
        if (mode_q == 2'd3 && ev) begin
          tmr <= '0;
          slice_idx <= ev_idx;
          position_sync <= 1'b1;
          turn_sync <= k == 0;
          // counter restarts at 1 so the next capture equals the cycles between index events
          if (k == 0) begin
            turn_period <= tcnt;
            tcnt <= PERIOD_W'(1);
            stalled <= 1'b0;
            seen0 <= 1'b1;
            period_valid <= seen0 && tcnt != PMAX;
          end
        end else if (run && wrap) begin
          tmr <= '0;
          slice_idx <= slice_idx + 1'b1;
          position_sync <= 1'b1;
          turn_sync <= last;
          p1 <= sp1;
          if (mode_q == 2'd2 && last && ramp > sp1) ramp <= ramp - 1'b1;
        end else if (run) tmr <= tmr + 1'b1;
      end
    end
endmodule

// File: tb/tb_position_sync_gen.sv
// tb_position_sync_gen: directed checks of emulate, ramp, hall-driven, stall, reset and mode-switch behaviour
module tb_position_sync_gen;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [1:0] m1 = 2'd0;
  logic [23:0] sp = 24'd10;
  logic [11:0] sp_b = 12'd10;
  logic [1:0] hall = 2'b11;
  logic h1 = 1'b1;
  logic ps, ts, pv, st, ps1, ts1, pv1, st1;
  logic [7:0] idx;
  logic [3:0] idx1;
  logic [23:0] tp;
  logic [11:0] tp1;
  int cyc = 0;
  int base = 0;
  int compared = 0;
  int mismatched = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  position_sync_gen #(.SLICES(256), .NB_SENSORS(2), .PERIOD_W(24), .DEBOUNCE(16), .RAMP_START(20)) u0 (
    .clk(clk), .nrst(nrst), .mode(mode), .slice_period(sp), .hall_in(hall),
    .position_sync(ps), .turn_sync(ts), .slice_idx(idx), .turn_period(tp),
    .period_valid(pv), .stalled(st));
  position_sync_gen #(.SLICES(16), .NB_SENSORS(1), .PERIOD_W(12), .DEBOUNCE(16), .RAMP_START(20)) u1 (
    .clk(clk), .nrst(nrst), .mode(m1), .slice_period(sp_b), .hall_in(h1),
    .position_sync(ps1), .turn_sync(ts1), .slice_idx(idx1), .turn_period(tp1),
    .period_valid(pv1), .stalled(st1));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    compared++;
    assert (obs === want) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask
  task automatic at(input int n);
    while (cyc < base + n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic enter(input logic [1:0] m);
    @(posedge clk);
    #1;
    mode = m;
    base = cyc + 1;
  endtask
  task automatic pulse0(input string tag, input logic p, input logic t, input int i);
    chk({tag, "_ps"}, 32'(ps), 32'(p));
    chk({tag, "_ts"}, 32'(ts), 32'(t));
    chk({tag, "_idx"}, 32'(idx), 32'(i));
  endtask
  task automatic pulse1(input string tag, input logic p, input logic t, input int i);
    chk({tag, "_ps"}, 32'(ps1), 32'(p));
    chk({tag, "_ts"}, 32'(ts1), 32'(t));
    chk({tag, "_idx"}, 32'(idx1), 32'(i));
  endtask
  initial begin
    #12;
    pulse0("rst0", 1'b0, 1'b0, 0);
    chk("rst0_tp", 32'(tp), 0);
    chk("rst0_pv", 32'(pv), 0);
    chk("rst0_st", 32'(st), 0);
    pulse1("rst1", 1'b0, 1'b0, 0);
    chk("rst1_tp", 32'(tp1), 0);
    chk("rst1_pv", 32'(pv1), 0);
    chk("rst1_st", 32'(st1), 0);
    nrst = 1'b1;
    enter(2'd1);
    at(9);    chk("m1_pre", 32'(ps), 0);
    at(10);   pulse0("m1_first", 1'b1, 1'b0, 1);
    at(11);   chk("m1_one_cycle", 32'(ps), 0);
    at(20);   pulse0("m1_second", 1'b1, 1'b0, 2);
    at(2550); pulse0("m1_s255", 1'b1, 1'b0, 255);
    at(2560); pulse0("m1_turn", 1'b1, 1'b1, 0);
    at(2575); chk("m1_mid_idx", 32'(idx), 1);
    nrst = 1'b0;
    #1;
    pulse0("async_rst", 1'b0, 1'b0, 0);
    chk("async_rst_pv", 32'(pv), 0);
    #3;
    nrst = 1'b1;
    sp = 24'd17;
    enter(2'd2);
    at(20);    pulse0("r_first", 1'b1, 1'b0, 1);
    at(5120);  pulse0("r_turn1", 1'b1, 1'b1, 0);
    at(5138);  chk("r_p19_pre", 32'(ps), 0);
    at(5139);  pulse0("r_p19", 1'b1, 1'b0, 1);
    at(9984);  pulse0("r_turn2", 1'b1, 1'b1, 0);
    at(10001); chk("r_p18_pre", 32'(ps), 0);
    at(10002); pulse0("r_p18", 1'b1, 1'b0, 1);
    at(14592); pulse0("r_turn3", 1'b1, 1'b1, 0);
    at(14608); chk("r_p17_pre", 32'(ps), 0);
    at(14609); pulse0("r_p17", 1'b1, 1'b0, 1);
    at(18944); pulse0("r_turn4", 1'b1, 1'b1, 0);
    at(18960); chk("r_floor_pre", 32'(ps), 0);
    at(18961); pulse0("r_floor", 1'b1, 1'b0, 1);
    enter(2'd3);
    at(100);   hall[0] = 1'b0;
    at(118);   chk("h_latency_pre", 32'(ps), 0);
    at(119);   pulse0("h_ev0a", 1'b1, 1'b1, 0);
    chk("h_ev0a_pv", 32'(pv), 0);
    at(219);   chk("h_no_free", 32'(ps), 0);
    at(300);   hall[0] = 1'b1;
    at(25700); hall[0] = 1'b0;
    at(25719); pulse0("h_ev0b", 1'b1, 1'b1, 0);
    chk("h_tp", 32'(tp), 25600);
    chk("h_pv", 32'(pv), 1);
    at(25818); chk("h_free_pre", 32'(ps), 0);
    at(25819); pulse0("h_free1", 1'b1, 1'b0, 1);
    at(25900); hall[0] = 1'b1;
    at(25919); pulse0("h_free2", 1'b1, 1'b0, 2);
    at(26030); hall[1] = 1'b0;
    at(26049); pulse0("h_ev1", 1'b1, 1'b0, 128);
    at(26119); chk("h_timer_cleared", 32'(ps), 0);
    at(26149); pulse0("h_after_ev1", 1'b1, 1'b0, 129);
    at(26300); hall[1] = 1'b1;
    at(26400); hall = 2'b00;
    at(26419); pulse0("h_both_k0", 1'b1, 1'b1, 0);
    chk("h_both_tp", 32'(tp), 700);
    at(26420); pulse0("h_both_k1", 1'b1, 1'b0, 128);
    at(26421); chk("h_p2_pre", 32'(ps), 0);
    at(26422); pulse0("h_p2", 1'b1, 1'b0, 129);
    at(26600); hall = 2'b11;
    at(27000); hall[0] = 1'b0;
    at(27015); hall[0] = 1'b1;
    at(27100); pulse0("glitch_sched", 1'b1, 1'b0, 212);
    chk("glitch_tp", 32'(tp), 700);
    sp = 24'd10;
    enter(2'd1);
    at(10);    pulse0("sw_m1", 1'b1, 1'b0, 1);
    at(15);    mode = 2'd3;
    at(16);    pulse0("sw_abort", 1'b0, 1'b0, 0);
    chk("sw_pv", 32'(pv), 0);
    at(20);    chk("sw_no_old_wrap", 32'(ps), 0);
    at(40);    pulse0("sw_quiet", 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;
    m1 = 2'd3;
    base = cyc + 1;
    at(50);    h1 = 1'b0;
    at(69);    pulse1("s_ev_a", 1'b1, 1'b1, 0);
    chk("s_ev_a_pv", 32'(pv1), 0);
    at(150);   h1 = 1'b1;
    at(1050);  h1 = 1'b0;
    at(1069);  pulse1("s_ev_b", 1'b1, 1'b1, 0);
    chk("s_tp", 32'(tp1), 1000);
    chk("s_pv", 32'(pv1), 1);
    at(1130);  chk("s_free_pre", 32'(ps1), 0);
    at(1131);  pulse1("s_free", 1'b1, 1'b0, 1);
    at(1200);  h1 = 1'b1;
    at(5163);  chk("s_st_pre", 32'(st1), 0);
    chk("s_pv_pre", 32'(pv1), 1);
    at(5164);  chk("s_st", 32'(st1), 1);
    chk("s_st_pv", 32'(pv1), 0);
    at(5223);  chk("s_no_free", 32'(ps1), 0);
    at(5300);  chk("s_idx_frozen", 32'(idx1), 2);
    at(6000);  h1 = 1'b0;
    at(6019);  pulse1("s_recover", 1'b1, 1'b1, 0);
    chk("s_recover_st", 32'(st1), 0);
    chk("s_recover_pv", 32'(pv1), 0);
    chk("s_recover_tp", 32'(tp1), 4095);
    at(6274);  chk("s_recover_quiet", 32'(ps1), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
